// File: rtl/bdd_traverse_engine.sv
// Oblique decision-diagram traversal engine: host-loaded node tables, one classification per start.
// Optional BDD_MAC_PIPE_EN inserts a MAC register stage between FETCH and EVAL (3 cycles per node).
module bdd_traverse_engine #(
    parameter int NUM_ATTR  = 3,
    parameter int ATTR_W    = 8,
    parameter int COEF_W    = 8,
    parameter int THR_W     = 10,
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 32,
    parameter int CLASS_W   = 8,
    parameter int ROOT      = 0,
    parameter int MAX_DEPTH = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cfg_we,
    input  logic [ADDR_W-1:0]                  cfg_addr,
    input  logic [NUM_ATTR*COEF_W+THR_W-1:0]   cfg_wt,
    input  logic [2*ADDR_W:0]                  cfg_link,
    input  logic                               start,
    input  logic [NUM_ATTR*ATTR_W-1:0]         in_attr,
    output logic                               busy,
    output logic                               done,
    output logic [CLASS_W-1:0]                 out_class,
    output logic                               err_depth
);

    localparam int WT_W   = NUM_ATTR*COEF_W + THR_W;
    localparam int LINK_W = 1 + 2*ADDR_W;
    localparam int ACC_W  = ATTR_W + COEF_W + $clog2(NUM_ATTR);
    localparam int CMP_W  = (ACC_W > THR_W) ? ACC_W : THR_W;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DCNT_W = $clog2(MAX_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        MAC   = 2'd2,
        EVAL  = 2'd3
    } state_t;

    state_t                         state, state_d;
    logic [ADDR_W-1:0]              node_q, node_d;
    logic [DCNT_W-1:0]              depth_q, depth_d;
    logic [NUM_ATTR*ATTR_W-1:0]     attr_q, attr_d;
    logic                           busy_d, done_d, err_d;
    logic [CLASS_W-1:0]             class_d;

    logic [WT_W-1:0]                wt_mem   [DEPTH];
    logic [LINK_W-1:0]              link_mem [DEPTH];
    logic [WT_W-1:0]                wt_q;
    logic [LINK_W-1:0]              link_q;

    logic                           cfg_ok;
    logic [ACC_W-1:0]               sum;
    logic [ACC_W-1:0]               sum_eval;
    logic [THR_W-1:0]               thr;
    logic                           leaf;
    logic [ADDR_W-1:0]              child0, child1, next;
    logic                           take1;

    // Writes are refused while busy so a query always walks a stable table.
    assign cfg_ok = cfg_we && !busy && (32'(cfg_addr) < 32'(DEPTH));

    always_ff @(posedge clk) begin
        if (cfg_ok) begin
            wt_mem[cfg_addr[IDX_W-1:0]]   <= cfg_wt;
            link_mem[cfg_addr[IDX_W-1:0]] <= cfg_link;
        end
        if (state == FETCH) begin
            wt_q   <= wt_mem[node_q[IDX_W-1:0]];
            link_q <= link_mem[node_q[IDX_W-1:0]];
        end
    end

    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < NUM_ATTR; i++) begin
            sum = sum + ACC_W'(attr_q[i*ATTR_W +: ATTR_W])
                      * ACC_W'(wt_q[THR_W + i*COEF_W +: COEF_W]);
        end
    end

`ifdef BDD_MAC_PIPE_EN
    logic [ACC_W-1:0] sum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else if (state == MAC) begin
            sum_q <= sum;
        end
    end

    assign sum_eval = sum_q;
`else
    assign sum_eval = sum;
`endif

    assign thr    = wt_q[THR_W-1:0];
    assign leaf   = link_q[2*ADDR_W];
    assign child1 = link_q[2*ADDR_W-1:ADDR_W];
    assign child0 = link_q[ADDR_W-1:0];
    assign take1  = CMP_W'(sum_eval) >= CMP_W'(thr);
    assign next   = take1 ? child1 : child0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            node_q    <= '0;
            depth_q   <= '0;
            attr_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_depth <= 1'b0;
            out_class <= '0;
        end else begin
            state     <= state_d;
            node_q    <= node_d;
            depth_q   <= depth_d;
            attr_q    <= attr_d;
            busy      <= busy_d;
            done      <= done_d;
            err_depth <= err_d;
            out_class <= class_d;
        end
    end

    always_comb begin
        state_d = state;
        node_d  = node_q;
        depth_d = depth_q;
        attr_d  = attr_q;
        busy_d  = busy;
        done_d  = 1'b0;
        err_d   = 1'b0;
        class_d = out_class;

        unique case (state)
            IDLE: begin
                if (start) begin
                    attr_d  = in_attr;
                    node_d  = ADDR_W'(ROOT);
                    depth_d = '0;
                    busy_d  = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
`ifdef BDD_MAC_PIPE_EN
                state_d = MAC;
`else
                state_d = EVAL;
`endif
            end
            MAC: begin
                state_d = EVAL;
            end
            EVAL: begin
                if (leaf) begin
                    class_d = child0[CLASS_W-1:0];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    depth_d = depth_q + 1'b1;
                    // Watchdog and out-of-table successor both end the query with an error.
                    if (depth_d == DCNT_W'(MAX_DEPTH) || 32'(next) >= 32'(DEPTH)) begin
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        node_d  = next;
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/bdd_traverse_engine.md
Name: bdd_traverse_engine

Overview:
- Parametrised oblique decision-diagram traversal engine: host loads node tables through a write port, then issues one classification per start pulse.
- Each internal node compares a weighted sum of NUM_ATTR attributes against a threshold and branches to child0 or child1; a leaf node returns a class.
- Successor to the fixed 3-attribute/8-bit accelerator top. Adds generic widths and depth, a start/done handshake, asynchronous reset and a path-depth watchdog.

Parameters:
- NUM_ATTR, 3, number of attributes per sample.
- ATTR_W, 8, bits per attribute (unsigned).
- COEF_W, 8, bits per node coefficient (unsigned).
- THR_W, 10, node threshold width (unsigned).
- ADDR_W, 8, node address width.
- DEPTH, 32, node table entries (≤ 2**ADDR_W).
- CLASS_W, 8, class width (≤ ADDR_W).
- ROOT, 0, root node address.
- MAX_DEPTH, 16, maximum internal nodes visited per query.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  node table write enable.
- cfg_addr  in  ADDR_W  node table write address.
- cfg_wt  in  NUM_ATTR*COEF_W+THR_W  weight word, {coef[NUM_ATTR-1]..coef[0], thr}.
- cfg_link  in  1+2*ADDR_W  link word, {leaf, child1, child0}; for a leaf, class = child0[CLASS_W-1:0].
- start  in  1  query request, sampled only in IDLE.
- in_attr  in  NUM_ATTR*ATTR_W  attributes, attr[0] in the LSBs.
- busy  out  1  high from the start-accept edge until the done edge.
- done  out  1  one-cycle pulse: result valid.
- out_class  out  CLASS_W  result, held until the next done.
- err_depth  out  1  qualifies done: the depth limit was hit.

Behaviour:
- Reset (asynchronous): state IDLE; busy=0, done=0, err_depth=0, out_class=0, depth counter 0. Table contents are not reset.
- Table: two synchronous-write, registered-read arrays of DEPTH entries.
  - Writes with cfg_addr ≥ DEPTH are dropped.
  - cfg_we while busy=1 is dropped, so a query always sees a stable table.
  - A write in IDLE on the same edge as start is performed; the query still reads the new data because the read starts in FETCH.
- FSM states: IDLE, FETCH, EVAL.
- IDLE:
  - start=1 latches in_attr, sets node address to ROOT, clears the depth counter, sets busy=1 and moves to FETCH.
  - done and err_depth are 0 in every state except on the exit-from-EVAL cycle.
- FETCH: presents the node address to both arrays and moves to EVAL (read data is registered at this edge).
- EVAL, leaf=1: out_class ← child0[CLASS_W-1:0], done=1 for one cycle, busy=0, state IDLE.
- EVAL, leaf=0:
  - sum = Σ attr[i]*coef[i], width ACC_W = ATTR_W+COEF_W+clog2(NUM_ATTR), no overflow possible.
  - Comparison is unsigned, with both operands zero-extended to max(ACC_W, THR_W).
  - sum ≥ thr → next = child1; otherwise next = child0.
  - Depth counter increments.
  - If the counter reaches MAX_DEPTH, or next ≥ DEPTH: done=1, err_depth=1, out_class is unchanged, busy=0, state IDLE.
  - Otherwise the node address becomes next and the state returns to FETCH.
- Latency: done asserts 2*N cycles after the start-accept edge, where N = nodes visited including the leaf.
- start while busy is ignored; there is no queueing.
- rst mid-query aborts it immediately; no done is produced.

Optional Feature:
- BDD_MAC_PIPE_EN defined: adds a MAC state between FETCH and EVAL that registers sum before the compare.
  - Cost is 3 cycles per node; latency becomes 3*N.
  - Leaf nodes also pass through MAC.
- Undefined: 2 cycles per node; sum and compare are combinational in EVAL.

Test Plan:
- Single leaf: node0 = leaf, class 8'd7; start → done at +2 cycles, out_class=7, err_depth=0, busy high for exactly 2 cycles.
- Two-level branch (in_attr {14,2,49}):
  - node0 coef {0,0,1}, thr 40, child1=2, child0=1; node2 leaf class 5; node1 leaf class 9.
  - Expect done at +4, out_class=5.
  - Set thr=50 → out_class=9.
- Weighted sum boundary: node0 coef {1,1,1}, thr 65, sum 65 → child1 taken; thr 66 → child0 taken.
- Depth watchdog: node0 internal with child0=child1=0, MAX_DEPTH=16 → done with err_depth=1 at +32, out_class unchanged from the previous query.
- Protocol:
  - start held high during busy → exactly one done.
  - cfg_we during busy → entry unchanged on readback query.
  - rst asserted mid-query → busy=0 immediately, no done; next start behaves normally.
- With BDD_MAC_PIPE_EN: repeat the two-level case → done at +6, out_class=5.
